// File: rtl/shake256_host_driver.sv
// Host-side initiator for the SHAKE256 Keccak core: sends a length header, forwards
// the message, returns the requested number of output words, then force-stops the core.
module shake256_host_driver #(
    parameter int WIN   = 32,
    parameter int WOUT  = 32,
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len_bits,
    input  logic [LEN_W-1:0] out_len_bits,
    output logic             busy,
    output logic             done,
    input  logic [WIN-1:0]   msg_data,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic [WOUT-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIN-1:0]   k_din,
    output logic             k_din_valid,
    input  logic             k_din_ready,
    input  logic [WOUT-1:0]  k_dout,
    input  logic             k_dout_valid,
    output logic             k_dout_ready,
    output logic             k_force_done,
    input  logic             k_force_done_ack
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR0  = 3'd1;
    localparam logic [2:0] S_HDR1  = 3'd2;
    localparam logic [2:0] S_MSG   = 3'd3;
    localparam logic [2:0] S_SQZ   = 3'd4;
    localparam logic [2:0] S_FORCE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [LEN_W-1:0] WIN_L  = LEN_W'(WIN);
    localparam logic [LEN_W-1:0] WOUT_L = LEN_W'(WOUT);
    localparam logic [LEN_W-1:0] ONE_L  = LEN_W'(1);

    logic [2:0]       state_reg, state_next;
    logic [LEN_W-1:0] msg_len_reg, msg_len_next;
    logic [LEN_W-1:0] out_len_reg, out_len_next;
    logic [LEN_W-1:0] nmsg_reg, nmsg_next;
    logic [LEN_W-1:0] nout_reg, nout_next;
    logic [LEN_W-1:0] rem_reg, rem_next;
    logic [LEN_W-1:0] msg_cnt_reg, msg_cnt_next;
    logic [LEN_W-1:0] out_cnt_reg, out_cnt_next;
    logic [WOUT-1:0]  out_data_reg, out_data_next;
    logic             out_valid_reg, out_valid_next;

    logic [WOUT-1:0]  tail_mask;
    logic             last_word;
    logic             dout_load;
    logic             out_take;
    logic [2:0]       after_msg_state;

    // Bit gi of the final partial word survives only if it lies in the upper rem bits.
    generate
        for (genvar gi = 0; gi < WOUT; gi++) begin : g_mask
            assign tail_mask[gi] = (LEN_W'(WOUT - gi) <= rem_reg);
        end
    endgenerate

    assign last_word       = (out_cnt_reg == nout_reg - ONE_L) && (rem_reg != '0);
    assign dout_load       = (state_reg == S_SQZ) && k_dout_valid && k_dout_ready;
    assign out_take        = out_valid_reg && out_ready;
    assign after_msg_state = (nout_reg == '0) ? S_FORCE : S_SQZ;

    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE);
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;

    always_comb begin
        k_din        = '0;
        k_din_valid  = 1'b0;
        msg_ready    = 1'b0;
        k_dout_ready = 1'b0;
        k_force_done = 1'b0;
        case (state_reg)
            S_HDR0: begin
                k_din       = WIN'(out_len_reg);
                k_din_valid = 1'b1;
            end
            S_HDR1: begin
                k_din       = WIN'(msg_len_reg);
                k_din_valid = 1'b1;
            end
            S_MSG: begin
                k_din       = msg_data;
                k_din_valid = msg_valid;
                msg_ready   = k_din_ready;
            end
            S_SQZ: begin
                k_dout_ready = (out_cnt_reg != nout_reg) && (!out_valid_reg || out_ready);
            end
            S_FORCE: begin
                k_force_done = 1'b1;
                k_dout_ready = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        msg_len_next   = msg_len_reg;
        out_len_next   = out_len_reg;
        nmsg_next      = nmsg_reg;
        nout_next      = nout_reg;
        rem_next       = rem_reg;
        msg_cnt_next   = msg_cnt_reg;
        out_cnt_next   = out_cnt_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    msg_len_next   = msg_len_bits;
                    out_len_next   = out_len_bits;
                    nmsg_next      = msg_len_bits / WIN_L + {{(LEN_W-1){1'b0}}, (msg_len_bits % WIN_L) != '0};
                    nout_next      = out_len_bits / WOUT_L + {{(LEN_W-1){1'b0}}, (out_len_bits % WOUT_L) != '0};
                    rem_next       = out_len_bits % WOUT_L;
                    msg_cnt_next   = '0;
                    out_cnt_next   = '0;
                    out_valid_next = 1'b0;
                    state_next     = S_HDR0;
                end
            end
            S_HDR0: if (k_din_ready) state_next = S_HDR1;
            S_HDR1: if (k_din_ready) state_next = (nmsg_reg == '0) ? after_msg_state : S_MSG;
            S_MSG: begin
                if (msg_valid && k_din_ready) begin
                    msg_cnt_next = msg_cnt_reg + ONE_L;
                    if (msg_cnt_reg + ONE_L == nmsg_reg)
                        state_next = after_msg_state;
                end
            end
            S_SQZ: begin
                if (dout_load) begin
                    out_data_next  = last_word ? (k_dout & tail_mask) : k_dout;
                    out_valid_next = 1'b1;
                    out_cnt_next   = out_cnt_reg + ONE_L;
                end else if (out_take) begin
                    out_valid_next = 1'b0;
                end
                // All words loaded: leave once the buffer is empty or being drained.
                if ((out_cnt_reg == nout_reg) && (!out_valid_reg || out_ready))
                    state_next = S_FORCE;
            end
            S_FORCE: if (k_force_done_ack) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            msg_len_reg   <= '0;
            out_len_reg   <= '0;
            nmsg_reg      <= '0;
            nout_reg      <= '0;
            rem_reg       <= '0;
            msg_cnt_reg   <= '0;
            out_cnt_reg   <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            msg_len_reg   <= msg_len_next;
            out_len_reg   <= out_len_next;
            nmsg_reg      <= nmsg_next;
            nout_reg      <= nout_next;
            rem_reg       <= rem_next;
            msg_cnt_reg   <= msg_cnt_next;
            out_cnt_reg   <= out_cnt_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
        end
    end

endmodule

// File: tb/tb_shake256_host_driver.sv
// Bench for shake256_host_driver: a Keccak core model plus message source and output
// sink; expected header/message/output words are queued and compared on handshakes.
module tb_shake256_host_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] msg_len_bits = '0;
    logic [31:0] out_len_bits = '0;
    logic        busy, done;
    logic [31:0] msg_data = '0;
    logic        msg_valid = 1'b0;
    logic        msg_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] k_din;
    logic        k_din_valid;
    logic        k_din_ready = 1'b0;
    logic [31:0] k_dout = '0;
    logic        k_dout_valid = 1'b0;
    logic        k_dout_ready;
    logic        k_force_done;
    logic        k_force_done_ack = 1'b0;

    shake256_host_driver #(.WIN(32), .WOUT(32), .LEN_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .msg_len_bits(msg_len_bits), .out_len_bits(out_len_bits),
        .busy(busy), .done(done),
        .msg_data(msg_data), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .k_din(k_din), .k_din_valid(k_din_valid), .k_din_ready(k_din_ready),
        .k_dout(k_dout), .k_dout_valid(k_dout_valid), .k_dout_ready(k_dout_ready),
        .k_force_done(k_force_done), .k_force_done_ack(k_force_done_ack)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] din_q[$];
    logic [31:0] msg_q[$];
    logic [31:0] out_q[$];
    int          nout_m = 0;
    int          rem_m = 0;
    int          dout_idx = 0;
    int          out_taken = 0;
    int          done_cnt = 0;
    int          force_cnt = 0;
    int          cyc = 0;
    int          last_out_cyc = 0;
    int          done_cyc = 0;
    int          out_mode = 0;
    bit          job_active = 0;
    bit          core_finished = 0;
    bit          prev_force = 0;
    logic [31:0] job_seed = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] core_word(input int idx);
        if (idx == nout_m - 1) return 32'hDEADBEEF;
        return (32'(idx + 1) * 32'h9E3779B9) ^ job_seed;
    endfunction

    function automatic logic [31:0] expect_word(input int idx, input logic [31:0] w);
        logic [31:0] low_bits;
        if (idx == nout_m - 1 && rem_m != 0) begin
            low_bits = (32'h1 << (32 - rem_m)) - 32'h1;
            return w & ~low_bits;
        end
        return w;
    endfunction

    // Core / source / sink model: observe at negedge, update drivers just after posedge.
    initial begin
        bit msg_hs, dout_hs, force_s;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            msg_hs = 0; dout_hs = 0; force_s = 0;
            if (rst_n) begin
                if (k_din_valid && k_din_ready) begin
                    if (din_q.size() == 0) check("din_extra", 1, 0);
                    else begin e = din_q.pop_front(); check("din", k_din, e); end
                end
                msg_hs  = msg_valid && msg_ready;
                dout_hs = k_dout_valid && k_dout_ready;
                if (dout_hs) begin
                    if (dout_idx < nout_m) out_q.push_back(expect_word(dout_idx, k_dout));
                    else check("extra_only_in_force", k_force_done, 1);
                end
                if (out_valid && !out_ready) check("bp_ready", k_dout_ready, 0);
                if (out_valid && out_ready) begin
                    if (out_q.size() == 0) check("out_extra", 1, 0);
                    else begin e = out_q.pop_front(); check("out", out_data, e); end
                    out_taken++;
                    if (out_taken == nout_m) last_out_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("busy_at_done", busy, 1);
                end
                force_s = k_force_done;
                if (k_force_done && !prev_force) force_cnt++;
                prev_force = k_force_done;
            end
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (msg_hs) void'(msg_q.pop_front());
                if (!(msg_valid && !msg_hs)) msg_valid = (msg_q.size() > 0) && ($urandom_range(0, 3) != 0);
                msg_data = (msg_q.size() > 0) ? msg_q[0] : '0;
                k_din_ready = ($urandom_range(0, 3) != 0);
                if (dout_hs) dout_idx++;
                if (k_force_done_ack) begin
                    k_force_done_ack = 1'b0;
                    core_finished = 1;
                end else begin
                    k_force_done_ack = force_s;
                end
                k_dout_valid = job_active && (din_q.size() == 0) && !core_finished;
                k_dout = core_word(dout_idx);
                case (out_mode)
                    0: out_ready = 1'b1;
                    1: out_ready = ~out_ready;
                    default: out_ready = ($urandom_range(0, 1) == 1);
                endcase
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check(tag, {busy, done, out_valid, msg_ready, k_din_valid, k_dout_ready, k_force_done, out_data, k_din},
              '0);
    endtask

    task automatic run_job(input int mlen, input int olen, input int mode, input bit glitch, input bit abort);
        int nmsg;
        bit glitched;
        bit finished;
        nmsg = (mlen + 31) / 32;
        nout_m = (olen + 31) / 32;
        rem_m = olen % 32;
        dout_idx = 0; out_taken = 0; done_cnt = 0; force_cnt = 0;
        core_finished = 0; prev_force = 0;
        job_seed = $urandom;
        out_mode = mode;
        din_q.delete(); msg_q.delete(); out_q.delete();
        din_q.push_back(32'(olen));
        din_q.push_back(32'(mlen));
        for (int i = 0; i < nmsg; i++) begin
            msg_q.push_back($urandom);
            din_q.push_back(msg_q[i]);
        end
        job_active = 1;
        @(posedge clk); #1;
        start = 1'b1;
        msg_len_bits = 32'(mlen);
        out_len_bits = 32'(olen);
        @(posedge clk); #1;
        start = 1'b0;
        check("start_latency", {busy, k_din_valid}, 2'b11);
        check("hdr0_value", k_din, 32'(olen));
        glitched = 0;
        finished = 0;
        for (int c = 0; c < 3000 && !finished; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done_cnt > 0) finished = 1;
            else if (glitch && !glitched && din_q.size() > 0 && din_q.size() <= nmsg) begin
                glitched = 1;
                start = 1'b1;
                msg_len_bits = 32'd999;
                out_len_bits = 32'd7;
                check("busy_on_glitch", busy, 1);
            end else if (abort && out_taken >= 2) begin
                #2 rst_n = 1'b0;
                #1 check_idle_outputs("reset_outputs");
                job_active = 0;
                msg_q.delete(); din_q.delete(); out_q.delete();
                msg_valid = 1'b0; k_dout_valid = 1'b0; k_force_done_ack = 1'b0; out_ready = 1'b0;
                nout_m = 0;
                @(posedge clk); #3;
                rst_n = 1'b1;
                repeat (6) @(posedge clk);
                #1 check("no_done_after_reset", done_cnt, 0);
                check_idle_outputs("idle_after_reset");
                $display("[TB] job msg=%0d out=%0d aborted by reset after %0d words", mlen, olen, out_taken);
                return;
            end
        end
        if (!finished) check("done_timeout", 0, 1);
        check("idle_after_done", busy, 0);
        if (glitch) check("glitch_seen", glitched, 1);
        job_active = 0;
        check("din_remaining", din_q.size(), 0);
        check("out_remaining", out_q.size(), 0);
        check("out_count", out_taken, nout_m);
        check("force_pulses", force_cnt, 1);
        if (nout_m > 0) check("last_out_to_done", done_cyc - last_out_cyc, 3);
        repeat (4) @(posedge clk);
        #1 check("single_done", done_cnt, 1);
        $display("[TB] job msg=%0d out=%0d words=%0d extras_offered=%0d", mlen, olen, out_taken, dout_idx - nout_m);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("reset_state");
        #19 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_job(72, 80, 0, 1, 0);
        run_job(0, 64, 0, 0, 0);
        run_job(64, 256, 1, 0, 0);
        run_job(100, 256, 2, 0, 1);
        run_job(40, 96, 2, 0, 0);
        run_job(33, 31, 1, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/shake256_host_driver.md
Name: shake256_host_driver

Overview:
- Host-side initiator for the SHAKE256 Keccak core. It drives the core's din stream, consumes its dout stream, and terminates squeezing via force_done.
- Accepts a job: message length, output length, a message word stream, and an output sink. Emits a two-word header, forwards the message, returns exactly the requested output words, then force-stops the core and pulses done.
- Sits between the HQC sampler/hash controllers and the keccak top instance.

Parameters:
WIN, 32, core din width and message word width
WOUT, 32, core dout width and output word width
LEN_W, 32, width of bit-length fields; must be <= WIN

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  reset, asynchronous assert, active-low (one clock; reset is asynchronous and active-low)
start  in  1  job request; accepted only in IDLE
msg_len_bits  in  LEN_W  message length in bits; sampled on start
out_len_bits  in  LEN_W  requested output length in bits; sampled on start
busy  out  1  high from start acceptance until the done cycle inclusive
done  out  1  one-cycle pulse at job end
msg_data  in  WIN  message word
msg_valid  in  1  message word valid
msg_ready  out  1  message word accepted when valid&&ready
out_data  out  WOUT  output word
out_valid  out  1  output word valid
out_ready  in  1  sink ready
k_din  out  WIN  to core din
k_din_valid  out  1  to core din_valid
k_din_ready  in  1  from core din_ready
k_dout  in  WOUT  from core dout
k_dout_valid  in  1  from core dout_valid
k_dout_ready  out  1  to core dout_ready
k_force_done  out  1  to core force_done
k_force_done_ack  in  1  from core force_done_ack

Behaviour:
- Reset: state=IDLE; all outputs 0; counters and length registers 0. Reset mid-job abandons the job with no done pulse. The core shares this reset.
- Word counts are latched on start:
  - nmsg = ceil(msg_len_bits/WIN)
  - nout = ceil(out_len_bits/WOUT)
  - rem = out_len_bits mod WOUT
- States:
  - IDLE: busy=0. start moves to HDR0 and latches lengths. start in any other state is ignored.
  - HDR0: k_din = out_len_bits zero-extended, k_din_valid=1. On k_din_ready, go to HDR1.
  - HDR1: k_din = msg_len_bits zero-extended, k_din_valid=1. On k_din_ready, go to MSG, or to SQZ if nmsg==0.
  - MSG: combinational pass-through: k_din=msg_data, k_din_valid=msg_valid, msg_ready=k_din_ready. Each handshake increments msg_cnt. On the nmsg-th handshake, go to SQZ. The last partial word is passed unmodified; the core pads it.
  - SQZ: registered one-entry output buffer.
    - k_dout_ready = !out_valid || out_ready.
    - Load on k_dout_valid && k_dout_ready.
    - out_valid drops after the sink takes a word unless a new word loads in the same cycle; full throughput at 1 word/cycle.
    - The word with index nout-1 is masked when rem!=0: upper rem bits kept (MSB-first), lower WOUT-rem bits forced to 0.
    - After nout words are loaded, k_dout_ready=0. Once the buffer drains (out_valid=0 or taken this cycle), go to FORCE.
    - nout==0: go straight to FORCE.
  - FORCE: k_force_done=1 and k_dout_ready=1; stray core words are discarded and never reach out_*. When k_force_done_ack==1, drop k_force_done and go to DONE. The ack arrives 1 cycle after assertion.
  - DONE: done=1 and busy=1 for one cycle, then IDLE.
- msg_ready=0 outside MSG. out_valid=0 outside SQZ. k_din_valid=0 outside HDR0/HDR1/MSG.
- The counters are LEN_W wide and do not wrap for legal lengths.
- Latency: start to first k_din_valid is 1 cycle. Last out_data accepted to done is 3 cycles (FORCE, ack, DONE).

Test Plan:
- WIN=WOUT=32, msg_len=72, out_len=80, always-ready sink:
  - k_din sequence 0x50, 0x48, then 3 message words.
  - 3 out words returned; word 2 masked to its upper 16 bits (e.g. core 0xDEADBEEF gives 0xDEAD0000).
  - One k_force_done pulse, then done.
- msg_len=0, out_len=64: only the 2 header words are sent, MSG is skipped, 2 output words unmasked, done pulses once.
- Sink backpressure, out_ready toggling 1010…, out_len=256 (8 words):
  - no word lost or duplicated; out_data order equals core order.
  - k_dout_ready low whenever the buffer is full and out_ready=0.
- After the 8th word, the core keeps k_dout_valid=1 with extra words: no extra out_valid, k_dout_ready=0 until FORCE, extras discarded, done follows the ack.
- start pulsed during MSG: ignored, lengths unchanged. A second start after done begins a new job cleanly.
- rst_n asserted low mid-SQZ: outputs 0 immediately (asynchronously), no done pulse. The next start runs a full job correctly.
